// File: rtl/bounded_counter_if.sv
// Control/status bundle for bounded_counter.
// The step field exists only when COUNTER_STEP_EN is defined.
interface bounded_counter_if #(
    parameter int unsigned N = 8
);
    logic         clkEN;
    logic         load;
    logic [N-1:0] par_load;
    logic         en;
    logic         direction;
    logic [N-1:0] lower_bound;
    logic [N-1:0] upper_bound;
`ifdef COUNTER_STEP_EN
    logic [N-1:0] step;
`endif
    logic [1:0]   mode;
    logic         start;
    logic [N-1:0] W;
    logic         co;
    logic         wrap;
    logic         busy;
    logic         done;

    modport master (
`ifdef COUNTER_STEP_EN
        output step,
`endif
        output clkEN, load, par_load, en, direction, lower_bound, upper_bound,
        output mode, start,
        input  W, co, wrap, busy, done
    );

    modport slave (
`ifdef COUNTER_STEP_EN
        input  step,
`endif
        input  clkEN, load, par_load, en, direction, lower_bound, upper_bound,
        input  mode, start,
        output W, co, wrap, busy, done
    );
endinterface

// File: rtl/bounded_counter.sv
// Up/down counter with programmable bounds and wrap/saturate/one-shot/hold modes.
// COUNTER_STEP_EN selects a programmable step; otherwise the step is fixed at 1.
module bounded_counter #(
    parameter int unsigned N = 8
) (
    input  logic               clk,
    input  logic               reset,
    bounded_counter_if.slave   bus
);

    typedef enum logic [1:0] {
        M_WRAP    = 2'b00,
        M_SAT     = 2'b01,
        M_ONESHOT = 2'b10,
        M_HOLD    = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t       state, state_n;
    logic [N-1:0] w_q, w_n;
    logic         wrap_q, wrap_n;
    logic [N-1:0] stp;
    mode_t        mode;

    logic [N:0]   w_x, s_x, lb_x, ub_x, up_nxt, dn_nxt;
    logic         over, under, count_ok;

`ifdef COUNTER_STEP_EN
    assign stp = bus.step;
`else
    assign stp = N'(1);
`endif

    assign mode = mode_t'(bus.mode);

    // Widen by one bit so overflow past the top of the N-bit range is still seen.
    assign w_x    = {1'b0, w_q};
    assign s_x    = {1'b0, stp};
    assign lb_x   = {1'b0, bus.lower_bound};
    assign ub_x   = {1'b0, bus.upper_bound};
    assign up_nxt = w_x + s_x;
    assign dn_nxt = w_x - s_x;
    assign over   = up_nxt > ub_x;
    assign under  = w_x < (lb_x + s_x);

    always_comb begin
        count_ok = 1'b0;
        if (bus.en && (stp != '0) && (bus.lower_bound <= bus.upper_bound)) begin
            case (mode)
                M_WRAP, M_SAT: count_ok = 1'b1;
                M_ONESHOT:     count_ok = (state == RUN);
                default:       count_ok = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_n     = w_q;
        wrap_n  = 1'b0;
        state_n = state;
        if (bus.clkEN) begin
            if (mode != M_ONESHOT)
                state_n = IDLE;
            if (bus.load) begin
                w_n = bus.par_load;
            end else if (mode == M_ONESHOT && bus.start) begin
                w_n     = bus.direction ? bus.lower_bound : bus.upper_bound;
                state_n = RUN;
            end else if (count_ok) begin
                if (bus.direction) begin
                    if (over) begin
                        case (mode)
                            M_WRAP: begin
                                w_n    = bus.lower_bound;
                                wrap_n = 1'b1;
                            end
                            M_SAT: begin
                                w_n    = bus.upper_bound;
                                wrap_n = (w_q != bus.upper_bound);
                            end
                            default: begin
                                w_n     = bus.upper_bound;
                                wrap_n  = 1'b1;
                                state_n = DONE;
                            end
                        endcase
                    end else begin
                        w_n = up_nxt[N-1:0];
                    end
                end else begin
                    if (under) begin
                        case (mode)
                            M_WRAP: begin
                                w_n    = bus.upper_bound;
                                wrap_n = 1'b1;
                            end
                            M_SAT: begin
                                w_n    = bus.lower_bound;
                                wrap_n = (w_q != bus.lower_bound);
                            end
                            default: begin
                                w_n     = bus.lower_bound;
                                wrap_n  = 1'b1;
                                state_n = DONE;
                            end
                        endcase
                    end else begin
                        w_n = dn_nxt[N-1:0];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_q    <= '0;
            wrap_q <= 1'b0;
            state  <= IDLE;
        end else begin
            w_q    <= w_n;
            wrap_q <= wrap_n;
            state  <= state_n;
        end
    end

    assign bus.W    = w_q;
    assign bus.wrap = wrap_q;
    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.co   = bus.direction ? (w_q == bus.upper_bound) : (w_q == bus.lower_bound);

endmodule

// File: tb/tb_bounded_counter.sv
// Directed bench for bounded_counter with N=4; step-specific vectors run when COUNTER_STEP_EN is defined.
module tb_bounded_counter;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    bounded_counter_if #(.N(4)) bus ();

    bounded_counter #(.N(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [3:0] v);
        bus.load     = 1'b1;
        bus.par_load = v;
        tick(1);
        bus.load     = 1'b0;
    endtask

    initial begin
        reset           = 1'b0;
        bus.clkEN       = 1'b1;
        bus.load        = 1'b0;
        bus.par_load    = '0;
        bus.en          = 1'b1;
        bus.direction   = 1'b1;
        bus.lower_bound = 4'd0;
        bus.upper_bound = 4'd15;
        bus.mode        = 2'b00;
        bus.start       = 1'b0;
`ifdef COUNTER_STEP_EN
        bus.step        = 4'd1;
`endif
        // reset held while enabled
        tick(2);
        chk("rst_W", 32'(bus.W), 0);
        chk("rst_wrap", 32'(bus.wrap), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        reset = 1'b1;
        tick(1); chk("rel_W1", 32'(bus.W), 1);
        tick(1); chk("rel_W2", 32'(bus.W), 2);
        // asynchronous reset between edges
        #2 reset = 1'b0;
        #1 chk("async_rst_W", 32'(bus.W), 0);
        reset = 1'b1;
        tick(1); chk("after_async_W", 32'(bus.W), 1);

        // full-range wrap 14 -> 15 -> 0
        do_load(4'd14);
        chk("ld14_W", 32'(bus.W), 14);
        chk("ld14_co", 32'(bus.co), 0);
        tick(1); chk("r15_W", 32'(bus.W), 15); chk("r15_co", 32'(bus.co), 1); chk("r15_wrap", 32'(bus.wrap), 0);
        tick(1); chk("r0_W", 32'(bus.W), 0); chk("r0_wrap", 32'(bus.wrap), 1);
        tick(1); chk("r1_W", 32'(bus.W), 1); chk("r1_wrap", 32'(bus.wrap), 0);

        // wrap up within 2..5
        bus.lower_bound = 4'd2;
        bus.upper_bound = 4'd5;
        do_load(4'd4);
        chk("wu_ld_W", 32'(bus.W), 4);
        tick(1); chk("wu5_W", 32'(bus.W), 5); chk("wu5_wrap", 32'(bus.wrap), 0);
        tick(1); chk("wu2_W", 32'(bus.W), 2); chk("wu2_wrap", 32'(bus.wrap), 1);
        tick(1); chk("wu3_W", 32'(bus.W), 3); chk("wu3_wrap", 32'(bus.wrap), 0);

        // load beats a boundary, then clkEN low freezes
        do_load(4'd5);
        bus.load     = 1'b1;
        bus.par_load = 4'd7;
        tick(1);
        bus.load     = 1'b0;
        chk("pri_W", 32'(bus.W), 7);
        chk("pri_wrap", 32'(bus.wrap), 0);
        bus.clkEN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1); chk("ce0_W", 32'(bus.W), 7);
        end
        bus.clkEN = 1'b1;
        tick(1); chk("above_W", 32'(bus.W), 2); chk("above_wrap", 32'(bus.wrap), 1);
        bus.clkEN = 1'b0;
        tick(1); chk("ce0_wrapclr", 32'(bus.wrap), 0); chk("ce0_W2", 32'(bus.W), 2);
        bus.clkEN = 1'b1;

        // hold mode
        bus.mode = 2'b11;
        tick(2); chk("hold_W", 32'(bus.W), 2);

        // saturate down within 3..12
        bus.mode        = 2'b01;
        bus.direction   = 1'b0;
        bus.lower_bound = 4'd3;
        bus.upper_bound = 4'd12;
        do_load(4'd5);
        tick(1); chk("sd4_W", 32'(bus.W), 4);
        tick(1); chk("sd3_W", 32'(bus.W), 3); chk("sd3_wrap", 32'(bus.wrap), 0); chk("sd3_co", 32'(bus.co), 1);
        tick(1); chk("sd3b_W", 32'(bus.W), 3); chk("sd3b_wrap", 32'(bus.wrap), 0);
        do_load(4'd1);
        tick(1); chk("sdlo_W", 32'(bus.W), 3); chk("sdlo_wrap", 32'(bus.wrap), 1);
        tick(1); chk("sdlo2_wrap", 32'(bus.wrap), 0);

        // inverted bounds suppress counting, load still works
        bus.mode        = 2'b00;
        bus.direction   = 1'b1;
        bus.lower_bound = 4'd9;
        bus.upper_bound = 4'd2;
        do_load(4'd5);
        tick(2); chk("inv_W", 32'(bus.W), 5);
        do_load(4'd6);
        chk("inv_ld_W", 32'(bus.W), 6);

        // one-shot up within 0..3
        bus.mode        = 2'b10;
        bus.lower_bound = 4'd0;
        bus.upper_bound = 4'd3;
        tick(1); chk("os_idle_W", 32'(bus.W), 6); chk("os_idle_busy", 32'(bus.busy), 0);
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        chk("os_st_W", 32'(bus.W), 0); chk("os_st_busy", 32'(bus.busy), 1); chk("os_st_done", 32'(bus.done), 0);
        tick(1); chk("os1_W", 32'(bus.W), 1);
        tick(1); chk("os2_W", 32'(bus.W), 2);
        tick(1); chk("os3_W", 32'(bus.W), 3); chk("os3_busy", 32'(bus.busy), 1);
        tick(1); chk("osd_W", 32'(bus.W), 3); chk("osd_done", 32'(bus.done), 1);
        chk("osd_busy", 32'(bus.busy), 0); chk("osd_wrap", 32'(bus.wrap), 1);
        tick(1); chk("osd2_W", 32'(bus.W), 3); chk("osd2_wrap", 32'(bus.wrap), 0); chk("osd2_done", 32'(bus.done), 1);
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        chk("os_re_W", 32'(bus.W), 0); chk("os_re_busy", 32'(bus.busy), 1); chk("os_re_done", 32'(bus.done), 0);
        tick(1); chk("os_re1_W", 32'(bus.W), 1);
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        chk("os_rr_W", 32'(bus.W), 0); chk("os_rr_busy", 32'(bus.busy), 1);
        bus.mode = 2'b00;
        tick(1); chk("os_exit_busy", 32'(bus.busy), 0); chk("os_exit_W", 32'(bus.W), 1);
        bus.mode      = 2'b10;
        bus.direction = 1'b0;
        bus.start     = 1'b1;
        tick(1);
        bus.start     = 1'b0;
        chk("osdn_W", 32'(bus.W), 3); chk("osdn_busy", 32'(bus.busy), 1);
        tick(1); chk("osdn2_W", 32'(bus.W), 2);

`ifdef COUNTER_STEP_EN
        // step 3 wrap up within 2..9
        bus.mode        = 2'b00;
        bus.direction   = 1'b1;
        bus.lower_bound = 4'd2;
        bus.upper_bound = 4'd9;
        bus.step        = 4'd3;
        do_load(4'd2);
        tick(1); chk("s3_5", 32'(bus.W), 5);
        tick(1); chk("s3_8", 32'(bus.W), 8); chk("s3_8_wrap", 32'(bus.wrap), 0);
        tick(1); chk("s3_2", 32'(bus.W), 2); chk("s3_2_wrap", 32'(bus.wrap), 1);
        tick(1); chk("s3_5b", 32'(bus.W), 5); chk("s3_5b_wrap", 32'(bus.wrap), 0);

        // step 4 saturate down within 3..12
        bus.mode        = 2'b01;
        bus.direction   = 1'b0;
        bus.lower_bound = 4'd3;
        bus.upper_bound = 4'd12;
        bus.step        = 4'd4;
        do_load(4'd10);
        tick(1); chk("s4_6", 32'(bus.W), 6);
        tick(1); chk("s4_3", 32'(bus.W), 3); chk("s4_3_wrap", 32'(bus.wrap), 1); chk("s4_3_co", 32'(bus.co), 1);
        tick(1); chk("s4_3b", 32'(bus.W), 3); chk("s4_3b_wrap", 32'(bus.wrap), 0);

        // step 2 one-shot within 0..5
        bus.mode        = 2'b10;
        bus.direction   = 1'b1;
        bus.lower_bound = 4'd0;
        bus.upper_bound = 4'd5;
        bus.step        = 4'd2;
        bus.start       = 1'b1;
        tick(1);
        bus.start       = 1'b0;
        chk("s2_0", 32'(bus.W), 0); chk("s2_busy", 32'(bus.busy), 1);
        tick(1); chk("s2_2", 32'(bus.W), 2);
        tick(1); chk("s2_4", 32'(bus.W), 4);
        tick(1); chk("s2_5", 32'(bus.W), 5); chk("s2_done", 32'(bus.done), 1);
        tick(1); chk("s2_hold", 32'(bus.W), 5);
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        chk("s2_re_W", 32'(bus.W), 0); chk("s2_re_busy", 32'(bus.busy), 1);

        // zero step holds
        bus.mode = 2'b00;
        bus.step = 4'd0;
        do_load(4'd4);
        tick(2); chk("s0_W", 32'(bus.W), 4); chk("s0_wrap", 32'(bus.wrap), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
